// File: rtl/codec_pkg.sv
// Shared definitions for the codec keystream path: widths, the default
// Galois feedback mask, the key generator state encoding and the LFSR step.
package codec_pkg;

  localparam int KG_DW = 64;

  // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form
  localparam logic [KG_DW-1:0] KG_TAPS = 64'hD800_0000_0000_0000;

  // IDLE: unseeded, RUN: streaming, DRAIN: reseed waiting for output to empty
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } kg_state_e;

  // One Galois step: shift right, fold the feedback mask in when the LSB is set.
  // A nonzero input can never map to zero because the mask MSB is set.
  function automatic logic [KG_DW-1:0] lfsr_step(input logic [KG_DW-1:0] k,
                                                 input logic [KG_DW-1:0] taps);
    return (k >> 1) ^ (k[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/codec_lfsr.sv
// Key register: loadable, single-step Galois LFSR with async reset.
module codec_lfsr
  import codec_pkg::*;
#(
  parameter int             DW   = KG_DW,
  parameter logic [DW-1:0]  TAPS = KG_TAPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          step,
  output logic [DW-1:0] key
);

  // Load has priority; the owner never requests load and step together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key <= '0;
    end else if (load) begin
      key <= seed;
    end else if (step) begin
      key <= lfsr_step(key, TAPS);
    end
  end

endmodule

// File: rtl/codec_key_gen.sv
// Keystream generator and data/key pairing stage ahead of the XOR codec.
// Each accepted input beat is registered together with the current LFSR key
// so the codec can XOR out_data with out_key directly.
//
// Handshake: a beat moves on a port when valid && ready are both high at a
// rising clock edge. Valid, once raised, holds with its payload stable until
// that edge; ready may depend combinationally on the downstream ready.
module codec_key_gen
  import codec_pkg::*;
#(
  parameter int             DW   = KG_DW,
  parameter logic [DW-1:0]  TAPS = KG_TAPS,
  parameter int             CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_load,
  input  logic [DW-1:0] cfg_seed,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_key,
  output logic [CW-1:0] beat_cnt,
  output logic          seed_err,
  output logic          busy
);

  kg_state_e     state;
  kg_state_e     state_next;
  logic [DW-1:0] pend;
  logic [DW-1:0] key;
  logic [DW-1:0] load_val;
  logic          load;
  logic          accept;
  logic          seed_ok;
  logic          seed_zero;
  logic          drain_done;

  // A zero seed would lock the LFSR, so it is rejected outright.
  assign seed_zero = cfg_load && (cfg_seed == '0);
  assign seed_ok   = cfg_load && (cfg_seed != '0);

  codec_lfsr #(
    .DW   (DW),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .seed (load_val),
    .step (accept),
    .key  (key)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: seed moves IDLE->RUN, reseed parks in DRAIN until empty
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (seed_ok)    state_next = RUN;
      RUN:     if (seed_ok)    state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = RUN;
      default:                 state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake ready, busy flag and LFSR load control
  always_comb begin
    in_ready   = (state == RUN) && (!out_valid || out_ready);
    busy       = (state != RUN);
    drain_done = (state == DRAIN) && (!out_valid || out_ready);
    accept     = in_valid && in_ready;
    load       = ((state == IDLE) && seed_ok) || drain_done;
    // A seed arriving in the very cycle the drain completes is the newest
    // request, so it wins over the one parked in pend.
    load_val   = ((state == IDLE) || seed_ok) ? cfg_seed : pend;
  end

  // Pending seed: captured in RUN, overwritten by any later valid seed in DRAIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (seed_ok && (state != IDLE)) begin
      pend <= cfg_seed;
    end
  end

  // Output pair register: capture on accept, clear valid once taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_key   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_key   <= key;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Beat counter: restarts with every successful seed, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Zero-seed rejection pulse, one cycle after the offending strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_err <= 1'b0;
    end else begin
      seed_err <= seed_zero;
    end
  end

endmodule

// File: tb/tb_codec_key_gen.sv
// Bench for codec_key_gen: cycle-level reference model of the seeding and
// pairing rules, an expected-pair queue, directed corner cases and random traffic.
module tb_codec_key_gen;

  localparam logic [63:0] TAPS_REF = 64'hD800_0000_0000_0000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [63:0] cfg_seed;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [63:0] out_key;
  logic [15:0] beat_cnt;
  logic        seed_err;
  logic        busy;

  always #5 clk = ~clk;

  codec_key_gen dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_seed  (cfg_seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_key   (out_key),
    .beat_cnt  (beat_cnt),
    .seed_err  (seed_err),
    .busy      (busy)
  );

  // ---------------- scoreboard / model state ----------------
  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [127:0] exp_q[$];
  int           m_st;
  logic [63:0]  m_key;
  logic [63:0]  m_pend;
  int unsigned  m_cnt;
  bit           m_ov;
  bit           m_serr;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] k);
    return (k >> 1) ^ (k[0] ? TAPS_REF : 64'h0);
  endfunction

  task automatic model_reset();
    m_st   = M_IDLE;
    m_key  = '0;
    m_pend = '0;
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_serr = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_ov"},   out_valid, 0);
    check_val({tag, "_rdy"},  in_ready, 0);
    check_val({tag, "_data"}, out_data, 0);
    check_val({tag, "_key"},  out_key, 0);
    check_val({tag, "_cnt"},  beat_cnt, 0);
    check_val({tag, "_serr"}, seed_err, 0);
    check_val({tag, "_busy"}, busy, 1);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [63:0] d, input bit ld,
                       input logic [63:0] sd, input bit rdy);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_seed  = sd;
    out_ready = rdy;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: called 1 time unit after a rising edge with inputs driven.
  task automatic run_cycle();
    bit exp_rdy, acc, hs, ddone, sok;
    #3;
    exp_rdy = (m_st == M_RUN) && (!m_ov || out_ready);
    check_val("in_ready", in_ready, exp_rdy);
    acc   = in_valid && exp_rdy;
    hs    = m_ov && out_ready;
    sok   = cfg_load && (cfg_seed != 0);
    ddone = (m_st == M_DRAIN) && (!m_ov || out_ready);
    if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({in_data, m_key});
      m_key = ref_step(m_key);
      m_cnt = (m_cnt + 1) % 65536;
    end
    case (m_st)
      M_IDLE: if (sok) begin
        m_key = cfg_seed; m_cnt = 0; m_st = M_RUN;
      end
      M_RUN: if (sok) begin
        m_pend = cfg_seed; m_st = M_DRAIN;
      end
      default: begin
        if (ddone) begin
          m_key = sok ? cfg_seed : m_pend; m_cnt = 0; m_st = M_RUN;
        end else if (sok) begin
          m_pend = cfg_seed;
        end
      end
    endcase
    m_ov   = acc ? 1'b1 : (hs ? 1'b0 : m_ov);
    m_serr = cfg_load && (cfg_seed == 0);
    @(posedge clk);
    #1;
    check_val("out_valid", out_valid, m_ov);
    check_val("busy", busy, m_st != M_RUN);
    check_val("seed_err", seed_err, m_serr);
    check_val("beat_cnt", beat_cnt, 128'(m_cnt));
    if (m_ov) begin
      if (exp_q.size() == 0) check_val("pair_missing", 1, 0);
      else check_val("pair", {out_data, out_key}, exp_q[0]);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] key_tbl[3];

  initial begin
    key_tbl[0] = 64'h1;
    key_tbl[1] = 64'hD800_0000_0000_0000;
    key_tbl[2] = 64'h6C00_0000_0000_0000;
    model_reset();
    rst = 1'b1;
    drive(0, '0, 0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Beats offered before any seed are refused
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd64(), 0, '0, 1);
      run_cycle();
    end

    // Zero seed is rejected with a one-cycle error pulse
    drive(0, '0, 1, 64'h0, 1);
    run_cycle();
    check_val("zero_seed_err", seed_err, 1);
    drive(0, '0, 0, '0, 1);
    run_cycle();
    check_val("zero_seed_err_gone", seed_err, 0);
    check_val("zero_seed_busy", busy, 1);

    // Seed 1, three beats: known key sequence
    drive(0, '0, 1, 64'h1, 1);
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, rnd64(), 0, '0, 1);
      run_cycle();
      check_val("seed1_key", out_key, key_tbl[i]);
    end
    check_val("seed1_cnt", beat_cnt, 3);

    // Back-pressure for 5 cycles with a pair held
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd64(), 0, '0, 0);
      run_cycle();
    end
    check_val("stall_key", out_key, 64'h6C00_0000_0000_0000);

    // Reseed 5 while stalled: DRAIN until out_ready, then key 5, count 1
    drive(1, rnd64(), 1, 64'h5, 0);
    run_cycle();
    check_val("drain_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, rnd64(), 0, '0, 0);
      run_cycle();
    end
    drive(1, rnd64(), 0, '0, 1);
    run_cycle();
    drive(1, rnd64(), 0, '0, 1);
    run_cycle();
    check_val("reseed_key", out_key, 64'h5);
    check_val("reseed_cnt", beat_cnt, 1);

    // Random traffic with occasional (sometimes zero) reseeds
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 39) == 0,
            ($urandom_range(0, 3) == 0) ? 64'h0 : rnd64(), $urandom_range(0, 3) != 0);
      run_cycle();
    end

    // Fresh seed, settle, then a full counter period of back-to-back beats
    drive(0, '0, 1, rnd64() | 64'h1, 1);
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, '0, 1);
      run_cycle();
    end
    for (int i = 0; i < 65536; i++) begin
      drive(1, rnd64(), 0, '0, 1);
      run_cycle();
    end
    check_val("wrap_cnt", beat_cnt, 0);

    // Asynchronous reset mid-stream, checked before the next clock edge
    drive(1, rnd64(), 0, '0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Recover after reset
    drive(0, '0, 1, rnd64() | 64'h2, 1);
    run_cycle();
    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 1) != 0, rnd64(), 0, '0, $urandom_range(0, 2) != 0);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_key_gen.md
# codec_key_gen

Keystream generator and data/key pairing stage that sits directly upstream of the XOR `codec`. It accepts a 64-bit data stream over a valid/ready handshake and tags each accepted beat with a per-beat key from a seeded 64-bit Galois LFSR. It presents the pair registered on its output so the codec combines `out_data ^ out_key` with no further alignment. Software seeds the generator through a one-cycle load strobe; reseeding mid-stream drains in-flight data first.

## Interface
Parameters:
- `DW`, 64: data and key width.
- `TAPS`, 64'hD800_0000_0000_0000: Galois feedback mask (x^64+x^63+x^61+x^60+1).
- `CW`, 16: beat counter width.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_load`  in  1  one-cycle seed load strobe.
- `cfg_seed`  in  DW  seed value, sampled when `cfg_load`=1.
- `in_valid`  in  1  upstream data valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  DW  upstream data.
- `out_valid`  out  1  registered pair valid, toward the codec side.
- `out_ready`  in  1  downstream accepts the pair.
- `out_data`  out  DW  registered data, drives codec `data_i`.
- `out_key`  out  DW  registered key, drives codec `key`.
- `beat_cnt`  out  CW  beats accepted since last successful seed, wraps.
- `seed_err`  out  1  one-cycle pulse: zero seed rejected.
- `busy`  out  1  state != RUN.

## Operation
- States:
  - IDLE: unseeded. `in_ready`=0.
  - RUN: streaming.
  - DRAIN: reseed pending, waiting for the output register to empty.
- IDLE + `cfg_load` with nonzero seed: `lfsr<=cfg_seed`, `beat_cnt<=0`, go to RUN.
- RUN + `cfg_load` with nonzero seed: `pend<=cfg_seed`, go to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - In the cycle where `out_valid`=0, or where `out_valid&&out_ready`: `lfsr<=pend`, `beat_cnt<=0`, go to RUN.
  - A new valid `cfg_load` in DRAIN overwrites `pend`.
- `cfg_load` with `cfg_seed`=0 in any state: ignored (no state, LFSR or `pend` change). `seed_err`=1 on the next cycle only.
- Accept condition: `in_valid && in_ready`. `in_ready = (state==RUN) && (!out_valid || out_ready)`.
- On accept:
  - `out_data<=in_data`, `out_key<=lfsr`, `out_valid<=1`.
  - `lfsr<=step(lfsr)`, `beat_cnt<=beat_cnt+1` (mod 2^CW).
- `step(k) = (k>>1) ^ (k[0] ? TAPS : 0)`. This is never zero for a nonzero k.
- Output handshake:
  - `out_valid` falls after `out_valid&&out_ready` if no new accept occurs in the same cycle.
  - `out_data` and `out_key` are held stable while `out_valid && !out_ready`.
- Accept and `cfg_load` in the same RUN cycle: the beat takes the current key, then the block goes to DRAIN.

## Timing
- Reset values:
  - state=IDLE.
  - `lfsr`, `pend`, `out_data`, `out_key`=0.
  - `out_valid`=0, `in_ready`=0, `beat_cnt`=0, `seed_err`=0.
  - `busy`=1.
- Latency: 1 cycle, from accept to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reseed from IDLE: first beat accepted one cycle after `cfg_load`.
- Reseed from RUN with the output empty: DRAIN lasts exactly 1 cycle, so the block is back in RUN 2 cycles after `cfg_load`.
- The first beat after any seed S gets key S, the second gets step(S).
- Reset mid-operation: immediate return to reset values. Any pending pair is dropped.

## Structure
- Shared package `codec_pkg`: `DW`, default `TAPS`, state enum `kg_state_e` {IDLE, RUN, DRAIN}, and the `lfsr_step` function.
- One natural sub-module, `codec_lfsr`: LFSR register with load, step enable and async reset.
- Top level holds the FSM, the output pair register and `beat_cnt`.

## Test plan
- Seed 64'h1, send 3 beats with `out_ready`=1 -> `out_key` = 64'h1, 64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000. `beat_cnt`=3.
- Beats sent before any seed -> `in_ready` stays 0. Seed 0 -> `seed_err` pulses for 1 cycle, `busy` stays 1.
- Back-pressure: `out_ready`=0 for 5 cycles with `out_valid`=1 -> `out_data`/`out_key` held stable, `in_ready`=0, LFSR does not advance.
- Reseed 64'h5 while a pair is stalled -> DRAIN until `out_ready`. The first new beat gets key 64'h5 and `beat_cnt` restarts at 1.
- Stream 65536 beats -> `beat_cnt` wraps to 0. Keys match a reference LFSR model throughout.
- Async `rst` asserted mid-stream -> all outputs go to reset values without waiting for a clock edge.
